ac_stream_matcher: RTL and testbench

Parametrised sequential Aho-Corasick matching engine. It consumes one character per handshake and walks the goto table one entry per cycle. On a miss it follows failure links until a goto hit or the root is reached, then reports the new state and a match flag. It replaces the single-shot combinational table reader and sits between the character source and the match collector.

---
 rtl/ac_stream_matcher.sv | 181 ++++++++++++++++++
 tb/tb_ac_stream_matcher.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ac_stream_matcher.sv
// Sequential Aho-Corasick matcher: one character per handshake, one goto entry
// compared per cycle, failure links followed on a full-table miss.
// ROM images are supplied as packed parameters, entry i at bits [i*W +: W].
module ac_stream_matcher #(
  parameter int STATE_W     = 8,
  parameter int CHAR_W      = 4,
  parameter int GOTO_DEPTH  = 32,
  parameter int NUM_ENTRIES = 11,
  parameter int NUM_STATES  = 32,
  parameter logic [GOTO_DEPTH*STATE_W-1:0] GOTO_CUR_INIT = '0,
  parameter logic [GOTO_DEPTH*CHAR_W-1:0]  GOTO_CHR_INIT = '0,
  parameter logic [GOTO_DEPTH*STATE_W-1:0] GOTO_NXT_INIT = '0,
  parameter logic [NUM_STATES*STATE_W-1:0] FAIL_INIT     = '0,
  parameter logic [NUM_STATES-1:0]         OUT_INIT      = '0
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               CLEAR,
  input  logic               CHAR_VALID,
  input  logic [CHAR_W-1:0]  CHAR_IN,
  output logic               CHAR_READY,
  output logic [STATE_W-1:0] NOW_STATE_OUT,
  output logic               EN_MATCH,
  output logic               RESULT_VALID,
  output logic               FAIL_ERR
);

  localparam int IDX_W  = (GOTO_DEPTH > 1) ? $clog2(GOTO_DEPTH) : 1;
  localparam int STEP_W = $clog2(NUM_STATES) + 1;
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_ENTRIES - 1);
  localparam logic [STEP_W-1:0] STEP_LIMIT = STEP_W'(NUM_STATES);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } fsm_t;

  fsm_t               fsm_r;
  logic [STATE_W-1:0] state_r;
  logic [CHAR_W-1:0]  char_r;
  logic [IDX_W-1:0]   idx_r;
  logic [STEP_W-1:0]  steps_r;
  logic               ready_r;
  logic               result_r;
  logic               match_r;
  logic               fail_err_r;

  logic               hit_s;
  logic [STATE_W-1:0] nxt_s;
  logic [STATE_W-1:0] fail_s;
  logic [STEP_W-1:0]  steps_inc_s;

  // Out-of-range ROM reads never hit and return the root.
  function automatic logic goto_hit(input logic [IDX_W-1:0] i,
                                    input logic [STATE_W-1:0] s,
                                    input logic [CHAR_W-1:0] c);
    logic r;
    if (int'(i) < GOTO_DEPTH) begin
      r = (GOTO_CUR_INIT[int'(i)*STATE_W +: STATE_W] == s) &&
          (GOTO_CHR_INIT[int'(i)*CHAR_W +: CHAR_W] == c);
    end else begin
      r = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [STATE_W-1:0] goto_nxt(input logic [IDX_W-1:0] i);
    logic [STATE_W-1:0] r;
    if (int'(i) < GOTO_DEPTH) begin
      r = GOTO_NXT_INIT[int'(i)*STATE_W +: STATE_W];
    end else begin
      r = '0;
    end
    return r;
  endfunction

  // Failure ROM entry s-1 holds fail(s); state 0 has no failure link.
  function automatic logic [STATE_W-1:0] fail_of(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] r;
    if ((s != '0) && (int'(s) <= NUM_STATES)) begin
      r = FAIL_INIT[(int'(s) - 1)*STATE_W +: STATE_W];
    end else begin
      r = '0;
    end
    return r;
  endfunction

  function automatic logic out_flag(input logic [STATE_W-1:0] s);
    logic r;
    if (int'(s) < NUM_STATES) begin
      r = OUT_INIT[int'(s)];
    end else begin
      r = 1'b0;
    end
    return r;
  endfunction

  assign hit_s       = goto_hit(idx_r, state_r, char_r);
  assign nxt_s       = goto_nxt(idx_r);
  assign fail_s      = fail_of(state_r);
  assign steps_inc_s = steps_r + STEP_W'(1);

  // Handshake, table walk and failure-link traversal.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fsm_r      <= IDLE;
      state_r    <= '0;
      char_r     <= '0;
      idx_r      <= '0;
      steps_r    <= '0;
      ready_r    <= 1'b1;
      result_r   <= 1'b0;
      match_r    <= 1'b0;
      fail_err_r <= 1'b0;
    end else if (CLEAR) begin
      fsm_r    <= IDLE;
      state_r  <= '0;
      idx_r    <= '0;
      steps_r  <= '0;
      ready_r  <= 1'b1;
      result_r <= 1'b0;
      match_r  <= 1'b0;
    end else begin
      result_r <= 1'b0;
      match_r  <= 1'b0;
      case (fsm_r)
        IDLE: begin
          if (CHAR_VALID) begin
            char_r  <= CHAR_IN;
            idx_r   <= '0;
            steps_r <= '0;
            ready_r <= 1'b0;
            fsm_r   <= SCAN;
          end else begin
            ready_r <= 1'b1;
          end
        end
        SCAN: begin
          if (hit_s) begin
            state_r  <= nxt_s;
            idx_r    <= '0;
            fsm_r    <= IDLE;
            ready_r  <= 1'b1;
            result_r <= 1'b1;
            match_r  <= out_flag(nxt_s);
          end else if (idx_r != LAST_IDX) begin
            idx_r <= idx_r + IDX_W'(1);
          end else if (state_r == '0) begin
            idx_r    <= '0;
            fsm_r    <= IDLE;
            ready_r  <= 1'b1;
            result_r <= 1'b1;
          end else if (steps_inc_s >= STEP_LIMIT) begin
            // Failure chain never reached the root: give up and flag it.
            fail_err_r <= 1'b1;
            state_r    <= '0;
            idx_r      <= '0;
            fsm_r      <= IDLE;
            ready_r    <= 1'b1;
            result_r   <= 1'b1;
          end else begin
            state_r <= fail_s;
            idx_r   <= '0;
            steps_r <= steps_inc_s;
          end
        end
        default: begin
          fsm_r   <= IDLE;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign CHAR_READY    = ready_r;
  assign NOW_STATE_OUT = state_r;
  assign EN_MATCH      = match_r;
  assign RESULT_VALID  = result_r;
  assign FAIL_ERR      = fail_err_r;

endmodule

// File: tb/tb_ac_stream_matcher.sv
// Directed bench for ac_stream_matcher using a small 4-entry automaton;
// a second instance carries a self-looping failure link.
module tb_ac_stream_matcher;

  localparam int SW = 8;
  localparam int CW = 4;

  // Goto entries (cur,chr,nxt): (0,1,1) (1,2,2) (0,2,3) (3,3,4)
  localparam logic [32*SW-1:0] CUR_IMG  = {224'd0, 8'd3, 8'd0, 8'd1, 8'd0};
  localparam logic [32*CW-1:0] CHR_IMG  = {112'd0, 4'd3, 4'd2, 4'd2, 4'd1};
  localparam logic [32*SW-1:0] NXT_IMG  = {224'd0, 8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [32*SW-1:0] FAIL_IMG = {224'd0, 8'd0, 8'd0, 8'd3, 8'd0};
  localparam logic [32*SW-1:0] BAD_IMG  = {224'd0, 8'd0, 8'd0, 8'd3, 8'd1};
  localparam logic [31:0]      OUT_IMG  = 32'h0000_0014;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          valid;
  logic [CW-1:0] chr;
  logic          ready;
  logic [SW-1:0] state;
  logic          en;
  logic          rv;
  logic          ferr;

  logic          b_clear;
  logic          b_valid;
  logic [CW-1:0] b_chr;
  logic          b_ready;
  logic [SW-1:0] b_state;
  logic          b_en;
  logic          b_rv;
  logic          b_ferr;

  int n_checks;
  int n_fail;

  ac_stream_matcher #(
    .STATE_W(SW), .CHAR_W(CW), .GOTO_DEPTH(32), .NUM_ENTRIES(4), .NUM_STATES(32),
    .GOTO_CUR_INIT(CUR_IMG), .GOTO_CHR_INIT(CHR_IMG), .GOTO_NXT_INIT(NXT_IMG),
    .FAIL_INIT(FAIL_IMG), .OUT_INIT(OUT_IMG)
  ) dut (
    .CLK(clk), .RST(rst_n), .CLEAR(clear), .CHAR_VALID(valid), .CHAR_IN(chr),
    .CHAR_READY(ready), .NOW_STATE_OUT(state), .EN_MATCH(en),
    .RESULT_VALID(rv), .FAIL_ERR(ferr)
  );

  ac_stream_matcher #(
    .STATE_W(SW), .CHAR_W(CW), .GOTO_DEPTH(32), .NUM_ENTRIES(4), .NUM_STATES(32),
    .GOTO_CUR_INIT(CUR_IMG), .GOTO_CHR_INIT(CHR_IMG), .GOTO_NXT_INIT(NXT_IMG),
    .FAIL_INIT(BAD_IMG), .OUT_INIT(OUT_IMG)
  ) dut_bad (
    .CLK(clk), .RST(rst_n), .CLEAR(b_clear), .CHAR_VALID(b_valid), .CHAR_IN(b_chr),
    .CHAR_READY(b_ready), .NOW_STATE_OUT(b_state), .EN_MATCH(b_en),
    .RESULT_VALID(b_rv), .FAIL_ERR(b_ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one character, then count edges until RESULT_VALID (lat=-1 on timeout).
  task automatic send(input bit bad, input logic [CW-1:0] c, output int lat,
                      output logic rdy_scan, output logic rdy_res);
    if (bad) begin
      b_valid = 1'b1; b_chr = c;
    end else begin
      valid = 1'b1; chr = c;
    end
    @(posedge clk); #1;
    valid = 1'b0; b_valid = 1'b0;
    rdy_scan = bad ? b_ready : ready;
    rdy_res = 1'b0;
    lat = -1;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk); #1;
      if (bad ? b_rv : rv) begin
        lat = i;
        rdy_res = bad ? b_ready : ready;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear = 1'b0; valid = 1'b0; chr = '0;
    b_clear = 1'b0; b_valid = 1'b0; b_chr = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({ready, state, en, rv, ferr} !== {1'b1, 8'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got rdy=%0b st=%0d en=%0b rv=%0b ferr=%0b expected 1 0 0 0 0",
               ready, state, en, rv, ferr);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({ready, state, rv, b_ferr} !== {1'b1, 8'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%0b st=%0d rv=%0b bferr=%0b expected 1 0 0 0",
               ready, state, rv, b_ferr);
    end
  endtask

  task automatic test_stream();
    int lat;
    logic rs, rr;
    send(1'b0, 4'd1, lat, rs, rr);
    n_checks++;
    if ({lat, state, en, rs, rr} !== {32'sd1, 8'd1, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL stream_char1: got lat=%0d st=%0d en=%0b rdy_scan=%0b rdy_res=%0b expected 1 1 0 0 1",
               lat, state, en, rs, rr);
    end
    send(1'b0, 4'd2, lat, rs, rr);
    n_checks++;
    if ({lat, state, en, rr} !== {32'sd2, 8'd2, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL stream_char2: got lat=%0d st=%0d en=%0b rdy_res=%0b expected 2 2 1 1",
               lat, state, en, rr);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({rv, en, state} !== {1'b0, 1'b0, 8'd2}) begin
      n_fail++;
      $display("FAIL stream_pulse: got rv=%0b en=%0b st=%0d expected 0 0 2", rv, en, state);
    end
  endtask

  task automatic test_fail_walk();
    int lat;
    logic rs, rr;
    send(1'b0, 4'd3, lat, rs, rr);
    n_checks++;
    if ({lat, state, en} !== {32'sd8, 8'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL fail_walk: got lat=%0d st=%0d en=%0b expected 8 4 1", lat, state, en);
    end
  endtask

  task automatic test_clear();
    valid = 1'b1; chr = 4'd5;
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({ready, state} !== {1'b0, 8'd4}) begin
      n_fail++;
      $display("FAIL clear_pre: got rdy=%0b st=%0d expected 0 4", ready, state);
    end
    clear = 1'b1; valid = 1'b1; chr = 4'd1;
    @(posedge clk); #1;
    n_checks++;
    if ({ready, state, rv, en} !== {1'b1, 8'd0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL clear_effect: got rdy=%0b st=%0d rv=%0b en=%0b expected 1 0 0 0",
               ready, state, rv, en);
    end
    clear = 1'b0; valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({ready, state, rv} !== {1'b1, 8'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL clear_not_consumed: got rdy=%0b st=%0d rv=%0b expected 1 0 0", ready, state, rv);
    end
  endtask

  task automatic test_root_miss();
    int lat;
    logic rs, rr;
    send(1'b0, 4'd5, lat, rs, rr);
    n_checks++;
    if ({lat, state, en, rr} !== {32'sd4, 8'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL root_miss: got lat=%0d st=%0d en=%0b rdy=%0b expected 4 0 0 1", lat, state, en, rr);
    end
  endtask

  task automatic test_fail_err();
    int lat;
    logic rs, rr;
    send(1'b1, 4'd1, lat, rs, rr);
    n_checks++;
    if ({lat, b_state, b_ferr} !== {32'sd1, 8'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL ferr_setup: got lat=%0d st=%0d ferr=%0b expected 1 1 0", lat, b_state, b_ferr);
    end
    send(1'b1, 4'd5, lat, rs, rr);
    n_checks++;
    if ({lat, b_state, b_en, b_ferr} !== {32'sd128, 8'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL ferr_walk: got lat=%0d st=%0d en=%0b ferr=%0b expected 128 0 0 1",
               lat, b_state, b_en, b_ferr);
    end
    b_clear = 1'b1;
    @(posedge clk); #1;
    b_clear = 1'b0;
    n_checks++;
    if ({b_ferr, ferr} !== {1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL ferr_sticky: got bad=%0b good=%0b expected 1 0", b_ferr, ferr);
    end
    send(1'b1, 4'd1, lat, rs, rr);
    n_checks++;
    if ({lat, b_state, b_ferr} !== {32'sd1, 8'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL ferr_after: got lat=%0d st=%0d ferr=%0b expected 1 1 1", lat, b_state, b_ferr);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    logic rs, rr;
    send(1'b0, 4'd1, lat, rs, rr);
    valid = 1'b1; chr = 4'd5;
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({ready, state} !== {1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL areset_pre: got rdy=%0b st=%0d expected 0 1", ready, state);
    end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ready, state, en, rv, ferr} !== {1'b1, 8'd0, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL areset_now: got rdy=%0b st=%0d en=%0b rv=%0b ferr=%0b expected 1 0 0 0 0",
               ready, state, en, rv, ferr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_checks++;
    if ({ready, state, rv} !== {1'b1, 8'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL areset_dropped: got rdy=%0b st=%0d rv=%0b expected 1 0 0", ready, state, rv);
    end
    send(1'b0, 4'd1, lat, rs, rr);
    n_checks++;
    if ({lat, state} !== {32'sd1, 8'd1}) begin
      n_fail++;
      $display("FAIL areset_resume: got lat=%0d st=%0d expected 1 1", lat, state);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_stream();
    test_fail_walk();
    test_clear();
    test_root_miss();
    test_fail_err();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
